uart_packet_rx: RTL and testbench
=================================

Name: uart_packet_rx

Overview:
- Parametrised UART packet receiver; successor to the fixed 3-byte motion/lidar receiver.
- Deserialises a GPIO RX line and hunts for a sync byte. It then collects NUM_FIELDS payload bytes and, optionally, verifies a checksum.
- Publishes all fields atomically with a one-cycle packet_valid pulse.
- Sits between the board GPIO pin and the display/LED/control logic in the top level.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at defaults).
- NUM_FIELDS, 3, payload bytes per packet; legal range 1..16.
- SYNC_BYTE, 8'hAA, packet header value.
- TIMEOUT_BYTES, 4, allowed idle gap inside a packet, in byte-times (10*CLKS_PER_BIT clocks each).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  raw UART line from GPIO; asynchronous, idle high.
- fields  output  8*NUM_FIELDS  last committed payload; field k at [8k+7:8k]; field 0 is the first byte after sync.
- rx_byte  output  8  last correctly framed byte received, including sync and checksum bytes.
- byte_strobe  output  1  one-cycle pulse when rx_byte updates.
- packet_valid  output  1  one-cycle pulse when fields updates.
- frame_err  output  1  one-cycle pulse when a stop bit samples low.
- csum_err  output  1  one-cycle pulse on checksum mismatch.
- timeout_err  output  1  one-cycle pulse on intra-packet gap timeout.
- busy  output  1  high while the packet FSM is outside HUNT.

Behaviour:
- Reset: every output and register is 0, including fields, rx_byte and all pulses. Bit FSM goes to IDLE, packet FSM to HUNT. Reset mid-packet discards the partial packet.
- rx_in passes through a 2-flop synchroniser. All sampling uses the synchronised signal.
- Bit FSM:
  - IDLE: a falling edge starts a counter → START.
  - START: at CLKS_PER_BIT/2, if the line is high it was a glitch → IDLE, no strobe. If low → DATA.
  - DATA: 8 samples, LSB first, each CLKS_PER_BIT apart → STOP.
  - STOP: sample after CLKS_PER_BIT. High: rx_byte updates and byte_strobe pulses on the same cycle. Low: frame_err pulses, byte is dropped, then → IDLE.
- Framing errors:
  - A frame_err inside a packet aborts that packet → HUNT.
  - After a frame error, the FSM waits for the line to be high before re-arming IDLE.
- Packet FSM, advanced only on byte_strobe:
  - HUNT: byte == SYNC_BYTE → FIELDS with idx=0 and sum=0. Any other byte is ignored.
  - FIELDS: store the byte in the shadow slot idx, sum += byte (mod 256), idx++. When idx reaches NUM_FIELDS → CSUM if the feature is enabled, else COMMIT.
  - A SYNC_BYTE value arriving in FIELDS is payload, not a resync.
  - COMMIT: one cycle. Shadow copies to fields and packet_valid pulses → HUNT.
- Latency: fields and packet_valid update 1 clk after the final byte_strobe of the packet.
- Timeout: a gap counter clears on each byte_strobe and runs while not in HUNT. At TIMEOUT_BYTES*10*CLKS_PER_BIT clocks: timeout_err pulses, → HUNT, fields unchanged.
- Simultaneous events: a byte_strobe and a timeout terminal count in the same cycle → the byte wins and the counter clears.
- fields never shows a partial packet.

Optional Feature:
- Macro PKT_CHECKSUM_EN.
- Defined: a checksum byte follows the payload.
  - CSUM state: received byte == sum → COMMIT.
  - Mismatch → csum_err pulses, fields held, → HUNT.
  - The checksum byte is not itself added to the sum.
- Undefined: no CSUM state, commit directly after the last field, csum_err tied 0.

Test Plan:
- Defaults, macro off. Send AA 12 34 56 → fields=24'h563412 one clk after the 4th byte_strobe; packet_valid pulses once; rx_byte=8'h56.
- Send 55 AA AA 01 02 → leading 55 ignored; the second AA is field 0; fields=24'h0201AA.
- Send AA 12, then idle 4*10*434 clocks → timeout_err pulses once; busy falls; fields keeps its previous value; a following AA 01 02 03 commits 24'h030201.
- Send a byte with stop bit forced low mid-packet → frame_err pulses; no byte_strobe for it; packet aborted; no packet_valid.
- PKT_CHECKSUM_EN defined: AA 01 02 03 06 → commit 24'h030201. AA 01 02 03 07 → csum_err pulses; fields unchanged.
- 100 ns low glitch on idle rx_in → no byte_strobe. Assert rst_n low mid-packet → all outputs 0 immediately; next full packet commits normally.

Source files
------------

// File: rtl/uart_packet_rx.sv
// UART packet receiver: sync-byte hunt, NUM_FIELDS payload, atomic commit.
// Optional checksum byte after payload when PKT_CHECKSUM_EN is defined.
module uart_packet_rx #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          BAUD          = 115200,
  parameter int          NUM_FIELDS    = 3,
  parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_in,
  output logic [8*NUM_FIELDS-1:0] fields,
  output logic [7:0]              rx_byte,
  output logic                    byte_strobe,
  output logic                    packet_valid,
  output logic                    frame_err,
  output logic                    csum_err,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int CPB    = CLK_FREQ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int TO_LIM = TIMEOUT_BYTES * 10 * CPB;
  localparam int CW     = $clog2(CPB + 1);
  localparam int GW     = $clog2(TO_LIM + 1);
  localparam int IW     = $clog2(NUM_FIELDS + 1);

  localparam logic [CW-1:0] BIT_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [GW-1:0] TO_M1   = GW'(TO_LIM - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_FIELDS - 1);

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT
  } bstate_t;

  typedef enum logic [1:0] {
    P_HUNT,
    P_FIELDS,
    P_CSUM,
    P_COMMIT
  } pstate_t;

  bstate_t          bstate;
  pstate_t          pstate;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [IW-1:0]    idx;
  logic [GW-1:0]    gap;
  logic [8*NUM_FIELDS-1:0] shadow;
  logic [8*NUM_FIELDS-1:0] shadow_nx;
  logic             last_field;
  logic             tout_hit;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  // Bit-level deserialiser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta     <= 1'b0;
      rx_s        <= 1'b0;
      rx_prev     <= 1'b0;
      bstate      <= B_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_meta     <= rx_in;
      rx_s        <= rx_meta;
      rx_prev     <= rx_s;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      unique case (bstate)
        B_IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt    <= '0;
            bstate <= B_START;
          end
        end
        B_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            bstate  <= rx_s ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) bstate <= B_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte     <= shreg;
              byte_strobe <= 1'b1;
              bstate      <= B_IDLE;
            end else begin
              frame_err <= 1'b1;
              bstate    <= B_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_WAIT: begin
          if (rx_s) bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  always_comb begin
    shadow_nx = shadow;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (idx == IW'(k)) shadow_nx[8*k +: 8] = rx_byte;
    end
    last_field = (idx == LAST);
    tout_hit   = (pstate != P_HUNT) && !byte_strobe && (gap == TO_M1);
  end

  // Packet FSM; commit is written on the final strobe so fields lag it by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate       <= P_HUNT;
      idx          <= '0;
      gap          <= '0;
      shadow       <= '0;
      fields       <= '0;
      packet_valid <= 1'b0;
      csum_err     <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      packet_valid <= 1'b0;
      csum_err     <= 1'b0;
      timeout_err  <= 1'b0;
      if (byte_strobe || pstate == P_HUNT || gap == TO_M1) begin
        gap <= '0;
      end else begin
        gap <= gap + 1'b1;
      end
      unique case (pstate)
        P_HUNT: begin
          if (byte_strobe && rx_byte == SYNC_BYTE) begin
            pstate <= P_FIELDS;
            idx    <= '0;
            busy   <= 1'b1;
`ifdef PKT_CHECKSUM_EN
            sum    <= '0;
`endif
          end
        end
        P_FIELDS: begin
          if (frame_err) begin
            pstate <= P_HUNT;
            busy   <= 1'b0;
          end else if (byte_strobe) begin
            shadow <= shadow_nx;
            idx    <= idx + 1'b1;
`ifdef PKT_CHECKSUM_EN
            sum    <= sum + rx_byte;
            if (last_field) pstate <= P_CSUM;
`else
            if (last_field) begin
              fields       <= shadow_nx;
              packet_valid <= 1'b1;
              pstate       <= P_COMMIT;
            end
`endif
          end else if (tout_hit) begin
            timeout_err <= 1'b1;
            pstate      <= P_HUNT;
            busy        <= 1'b0;
          end
        end
        P_CSUM: begin
          if (frame_err) begin
            pstate <= P_HUNT;
            busy   <= 1'b0;
          end else if (byte_strobe) begin
`ifdef PKT_CHECKSUM_EN
            if (rx_byte == sum) begin
              fields       <= shadow;
              packet_valid <= 1'b1;
              pstate       <= P_COMMIT;
            end else begin
              csum_err <= 1'b1;
              pstate   <= P_HUNT;
              busy     <= 1'b0;
            end
`else
            pstate <= P_HUNT;
            busy   <= 1'b0;
`endif
          end else if (tout_hit) begin
            timeout_err <= 1'b1;
            pstate      <= P_HUNT;
            busy        <= 1'b0;
          end
        end
        P_COMMIT: begin
          pstate <= P_HUNT;
          busy   <= 1'b0;
        end
        default: begin
          pstate <= P_HUNT;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: packet-level model, randomized byte stream.
// Handles both PKT_CHECKSUM_EN builds.
module tb_uart_packet_rx;

  localparam int CLK_FREQ = 3200000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int N        = 3;
  localparam int TOB      = 4;
  localparam int LIM      = TOB * 10 * CPB;
  localparam logic [7:0] SYNC = 8'hAA;
`ifdef PKT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rx_in;
  logic [8*N-1:0] fields;
  logic [7:0]     rx_byte;
  logic           byte_strobe;
  logic           packet_valid;
  logic           frame_err;
  logic           csum_err;
  logic           timeout_err;
  logic           busy;

  always #5 clk = ~clk;

  uart_packet_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .NUM_FIELDS(N),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_BYTES(TOB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_in(rx_in),
    .fields(fields),
    .rx_byte(rx_byte),
    .byte_strobe(byte_strobe),
    .packet_valid(packet_valid),
    .frame_err(frame_err),
    .csum_err(csum_err),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]     exp_b[$];
  logic [8*N-1:0] exp_p[$];
  int exp_ferr = 0, exp_cerr = 0, exp_tout = 0;
  int n_strobe = 0, n_pkt = 0, n_ferr = 0, n_cerr = 0, n_tout = 0;

  bit         m_in = 1'b0;
  bit         m_ck = 1'b0;
  int         m_idx = 0;
  logic [7:0] m_buf[N];
  logic [7:0] m_sum = 8'h00;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push();
    logic [8*N-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[8*k +: 8] = m_buf[k];
    exp_p.push_back(p);
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_b.push_back(b);
    if (!m_in) begin
      if (b == SYNC) begin
        m_in = 1'b1; m_ck = 1'b0; m_idx = 0; m_sum = 8'h00;
      end
    end else if (m_ck) begin
      if (b == m_sum) model_push();
      else exp_cerr++;
      m_in = 1'b0;
    end else begin
      m_buf[m_idx] = b;
      m_sum = m_sum + b;
      m_idx++;
      if (m_idx == N) begin
        if (CK) m_ck = 1'b1;
        else begin
          model_push();
          m_in = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int bits);
    rx_in = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else begin
      exp_ferr++;
      m_in = 1'b0;
    end
    @(negedge clk);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop_ok;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_pkt3(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    send_byte(SYNC, 1'b1);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
    if (CK) send_byte(a + b + c, 1'b1);
  endtask

  // Per-cycle compare against the model queues
  bit prev_strobe = 1'b0;
  always @(negedge clk) begin
    logic [7:0]     eb;
    logic [8*N-1:0] ep;
    if (!rst_n) begin
      prev_strobe = 1'b0;
    end else begin
      if (byte_strobe) begin
        n_strobe++;
        checks++;
        if (exp_b.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected: got %h expected none", rx_byte);
        end else begin
          eb = exp_b.pop_front();
          if (rx_byte !== eb) begin
            failures++;
            $display("FAIL rx_byte: got %h expected %h", rx_byte, eb);
          end
        end
      end
      if (packet_valid) begin
        n_pkt++;
        checks++;
        if (exp_p.size() == 0) begin
          failures++;
          $display("FAIL pkt_unexpected: got %h expected none", fields);
        end else begin
          ep = exp_p.pop_front();
          if (fields !== ep) begin
            failures++;
            $display("FAIL fields: got %h expected %h", fields, ep);
          end
        end
        chk("pkt_latency", prev_strobe, 1'b1);
      end
      if (frame_err) n_ferr++;
      if (csum_err) n_cerr++;
      if (timeout_err) n_tout++;
      prev_strobe = byte_strobe;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, p0, f0, t0, cyc;
    logic [7:0] b;
    bit ok;

    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_fields", fields, '0);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_flags", {busy, byte_strobe, packet_valid, frame_err,
                        csum_err, timeout_err}, 6'b0);
    rst_n = 1'b1;
    idle(2);

    p0 = n_pkt;
    send_pkt3(8'h12, 8'h34, 8'h56);
    idle(1);
    chk("t1_fields", fields, 24'h563412);
    chk("t1_pkt_count", n_pkt - p0, 1);
    chk("t1_rx_byte", rx_byte, CK ? 8'h9C : 8'h56);

    send_byte(8'h55, 1'b1);
    send_pkt3(8'hAA, 8'h01, 8'h02);
    idle(1);
    chk("t2_fields", fields, 24'h0201AA);

    t0 = n_tout;
    send_byte(SYNC, 1'b1);
    send_byte(8'h12, 1'b1);
    chk("t3_busy_in_pkt", busy, 1'b1);
    exp_tout++;
    m_in = 1'b0;
    cyc = 0;
    while (n_tout == t0 && cyc < LIM + 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_tout_count", n_tout - t0, 1);
    chk("t3_tout_time", (cyc >= LIM - CPB) && (cyc <= LIM), 1'b1);
    idle(1);
    chk("t3_busy_low", busy, 1'b0);
    chk("t3_fields_held", fields, 24'h0201AA);
    send_pkt3(8'h01, 8'h02, 8'h03);
    idle(1);
    chk("t3_fields_next", fields, 24'h030201);

    s0 = n_strobe; f0 = n_ferr; p0 = n_pkt;
    send_byte(SYNC, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(2);
    chk("t4_ferr", n_ferr - f0, 1);
    chk("t4_strobes", n_strobe - s0, 2);
    chk("t4_no_pkt", n_pkt - p0, 0);
    chk("t4_busy", busy, 1'b0);

`ifdef PKT_CHECKSUM_EN
    send_pkt3(8'h01, 8'h02, 8'h03);
    idle(1);
    chk("t5_ck_ok", fields, 24'h030201);
    f0 = n_cerr;
    send_byte(SYNC, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h07, 1'b1);
    idle(1);
    chk("t5_cerr", n_cerr - f0, 1);
    chk("t5_fields_held", fields, 24'h030201);
`endif

    s0 = n_strobe;
    @(negedge clk);
    rx_in = 1'b0;
    #100;
    rx_in = 1'b1;
    idle(3);
    chk("t6_glitch_strobe", n_strobe - s0, 0);
    chk("t6_glitch_busy", busy, 1'b0);

    for (int i = 0; i < 60; i++) begin
      b  = ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom);
      ok = ($urandom_range(0, 19) != 0);
      send_byte(b, ok);
      idle($urandom_range(0, 2));
    end
    if (m_in) begin
      exp_tout++;
      m_in = 1'b0;
    end
    idle(TOB * 10 + 4);

    send_byte(SYNC, 1'b1);
    send_byte(8'h12, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_in = 1'b0;
    chk("t7_reset_fields", fields, '0);
    chk("t7_reset_rx_byte", rx_byte, 8'h00);
    chk("t7_reset_flags", {busy, byte_strobe, packet_valid, frame_err,
                           csum_err, timeout_err}, 6'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_pkt3(8'h0A, 8'h0B, 8'h0C);
    idle(2);
    chk("t7_fields", fields, 24'h0C0B0A);

    chk("end_bytes_left", exp_b.size(), 0);
    chk("end_pkts_left", exp_p.size(), 0);
    chk("end_ferr", n_ferr, exp_ferr);
    chk("end_cerr", n_cerr, exp_cerr);
    chk("end_tout", n_tout, exp_tout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
